// File: rtl/aes_model_pack.sv
// Shared AES model package: S-box tables, round constants and the GF(2^8) helpers used by the
// iterative AES datapaths. Byte k of a 128-bit block sits at bits [8k+7:8k], k = 4*col + row.
package aes_model_pack;

   typedef logic [15:0][7:0] state_t;

   typedef enum logic [2:0] {
      S_NO_KEY,
      S_EXPAND,
      S_IDLE,
      S_ROUND,
      S_DONE
   } aes_dec_state_e;

   localparam logic [7:0] RCON_TABLE [10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   localparam logic [7:0] SUB_BYTES_TABLE [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
      8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
      8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
      8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
      8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
      8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
      8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
      8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
      8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
      8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
      8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
      8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
      8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
      8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
      8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
      8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
      8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam logic [7:0] INV_SUB_BYTES_TABLE [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
      8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
      8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
      8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
      8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
      8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
      8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
      8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
      8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
      8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
      8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
      8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
      8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
      8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
      8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
      8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
      8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, m;
      p = 8'h00;
      x = a;
      m = b;
      for (int i = 0; i < 8; i++) begin
         if (m[0]) p = p ^ x;
         x = xtime(x);
         m = m >> 1;
      end
      return p;
   endfunction

   // Row r rotates right by r columns.
   function automatic state_t inv_shift_rows(input state_t s);
      state_t o;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[4'(4 * c + r)] = s[4'(4 * ((c - r) & 3) + r)];
         end
      end
      return o;
   endfunction

   function automatic state_t inv_sub_bytes(input state_t s);
      state_t o;
      for (int k = 0; k < 16; k++) o[4'(k)] = INV_SUB_BYTES_TABLE[s[4'(k)]];
      return o;
   endfunction

   function automatic state_t inv_mix_columns(input state_t s);
      state_t o;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[4'(4 * c)];
         a1 = s[4'(4 * c + 1)];
         a2 = s[4'(4 * c + 2)];
         a3 = s[4'(4 * c + 3)];
         o[4'(4 * c)]     = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
         o[4'(4 * c + 1)] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
         o[4'(4 * c + 2)] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
         o[4'(4 * c + 3)] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
      return o;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {SUB_BYTES_TABLE[w[31:24]], SUB_BYTES_TABLE[w[23:16]],
              SUB_BYTES_TABLE[w[15:8]], SUB_BYTES_TABLE[w[7:0]]};
   endfunction

   // Byte 0 of a word is the low byte, so the rotate moves it to the top.
   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[7:0], w[31:8]};
   endfunction

   function automatic logic [127:0] key_expand_step(input logic [127:0] k, input logic [7:0] rcon);
      logic [31:0] t, w0, w1, w2, w3;
      t  = sub_word(rot_word(k[127:96])) ^ {24'h000000, rcon};
      w0 = k[31:0] ^ t;
      w1 = k[63:32] ^ w0;
      w2 = k[95:64] ^ w1;
      w3 = k[127:96] ^ w2;
      return {w3, w2, w1, w0};
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse AES round; the final round leaves out InvMixColumns.
module aes_inv_round
   import aes_model_pack::*;
(
   input  state_t state_i,
   input  state_t round_key_i,
   input  logic   is_final_i,
   output state_t state_o
);

   state_t keyed;

   always_comb begin
      keyed   = inv_sub_bytes(inv_shift_rows(state_i)) ^ round_key_i;
      state_o = is_final_i ? keyed : inv_mix_columns(keyed);
   end

endmodule

// File: rtl/aes_decryptor.sv
// Iterative AES-128 decryptor: expands and stores all 11 round keys once per key load, then
// decrypts one block at one inverse round per clock behind valid/ready handshakes.
module aes_decryptor
   import aes_model_pack::*;
#(
   parameter int unsigned DATA_WIDTH_IN_BYTES = 16,  // only 16 (AES-128) is supported
   parameter int unsigned NUM_ROUNDS          = 10
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               key_valid,
   input  logic [8*DATA_WIDTH_IN_BYTES-1:0]   key,
   output logic                               key_ready,
   input  logic                               in_valid,
   input  logic [8*DATA_WIDTH_IN_BYTES-1:0]   in_data,
   output logic                               in_ready,
   output logic                               out_valid,
   output logic [8*DATA_WIDTH_IN_BYTES-1:0]   out_data,
   input  logic                               out_ready
);

   localparam int unsigned BlockW = 8 * DATA_WIDTH_IN_BYTES;

   aes_dec_state_e    state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   state_t            blk_q, blk_d;
   logic              out_valid_q, out_valid_d;
   logic [BlockW-1:0] out_data_q, out_data_d;

   // Round-key store is deliberately unreset; the FSM forces a key load after every reset.
   logic [127:0]      rk_q [NUM_ROUNDS+1];
   logic              rk_we;
   logic [3:0]        rk_waddr;
   logic [127:0]      rk_wdata;

   state_t            round_out;

   aes_inv_round u_inv_round (
      .state_i     (blk_q),
      .round_key_i (rk_q[cnt_q]),
      .is_final_i  (cnt_q == 4'd0),
      .state_o     (round_out)
   );

   assign key_ready = (state_q == S_NO_KEY) || (state_q == S_IDLE);
   assign in_ready  = (state_q == S_IDLE) && !key_valid;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      blk_d       = blk_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      rk_we       = 1'b0;
      rk_waddr    = cnt_q;
      rk_wdata    = key_expand_step(rk_q[cnt_q - 4'd1], RCON_TABLE[cnt_q - 4'd1]);

      unique case (state_q)
         S_NO_KEY: begin
            if (key_valid) begin
               rk_we    = 1'b1;
               rk_waddr = 4'd0;
               rk_wdata = key;
               cnt_d    = 4'd1;
               state_d  = S_EXPAND;
            end
         end
         S_EXPAND: begin
            rk_we = 1'b1;
            if (cnt_q == 4'(NUM_ROUNDS)) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_IDLE: begin
            // A key offer wins over a simultaneous data offer.
            if (key_valid) begin
               rk_we    = 1'b1;
               rk_waddr = 4'd0;
               rk_wdata = key;
               cnt_d    = 4'd1;
               state_d  = S_EXPAND;
            end else if (in_valid) begin
               blk_d   = in_data ^ rk_q[NUM_ROUNDS];
               cnt_d   = 4'(NUM_ROUNDS - 1);
               state_d = S_ROUND;
            end
         end
         S_ROUND: begin
            if (cnt_q == 4'd0) begin
               out_data_d  = round_out;
               out_valid_d = 1'b1;
               state_d     = S_DONE;
            end else begin
               blk_d = round_out;
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_NO_KEY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_NO_KEY;
         cnt_q       <= 4'd0;
         blk_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         blk_q       <= blk_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rk_we) rk_q[rk_waddr] <= rk_wdata;
   end

endmodule

// File: tb/tb_aes_decryptor.sv
// Directed bench for aes_decryptor: FIPS-197 vector table plus handshake and reset corner cases.
module tb_aes_decryptor;

   logic         clk, rst_n;
   logic         key_valid, key_ready, in_valid, in_ready, out_valid, out_ready;
   logic [127:0] key, in_data, out_data;

   int checks = 0;
   int errors = 0;

   localparam logic [127:0] C1_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
   localparam logic [127:0] C1_CT  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
   localparam logic [127:0] C1_PT  = 128'hffeeddccbbaa99887766554433221100;
   localparam logic [127:0] B_KEY  = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
   localparam logic [127:0] B_CT   = 128'h320b6a19978511dcfb09dc021d842539;
   localparam logic [127:0] B_PT   = 128'h340737e0a29831318d305a88a8f64332;

   typedef struct {
      logic [127:0] key;
      logic [127:0] ct;
      logic [127:0] pt;
   } vec_t;

   vec_t vecs [3];

   aes_decryptor dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_valid (key_valid),
      .key       (key),
      .key_ready (key_ready),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, required finish before 200000 ns");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, got, exp);
      end
   endtask

   // Waits for out_valid (bounded), checks latency and data, optionally stalls, then drains.
   task automatic wait_out(input logic [127:0] pt, input string name, input int hold,
                           input int start_n);
      int n;
      int bad;
      n   = start_n;
      bad = 0;
      while (!out_valid && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({name, "_latency"}, 128'(n), 128'd10);
      check({name, "_data"}, out_data, pt);
      repeat (hold) begin
         @(posedge clk);
         #1;
         if (out_valid !== 1'b1 || out_data !== pt || in_ready !== 1'b0 || key_ready !== 1'b0)
            bad++;
      end
      if (hold > 0) check({name, "_hold_bad_cycles"}, 128'(bad), 128'd0);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({name, "_out_valid_drop"}, 128'(out_valid), 128'd0);
      check({name, "_in_ready_after"}, 128'(in_ready), 128'd1);
   endtask

   task automatic load_key(input logic [127:0] k, input string name);
      int n;
      check({name, "_key_ready"}, 128'(key_ready), 128'd1);
      key_valid = 1'b1;
      key       = k;
      @(posedge clk);
      #1;
      key_valid = 1'b0;
      n = 0;
      while (!in_ready && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({name, "_expand_cycles"}, 128'(n), 128'd10);
   endtask

   task automatic run_block(input logic [127:0] ct, input logic [127:0] pt, input string name,
                            input int hold);
      check({name, "_in_ready"}, 128'(in_ready), 128'd1);
      in_valid = 1'b1;
      in_data  = ct;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_out(pt, name, hold, 0);
   endtask

   initial begin
      int n;
      int bad;
      vecs[0] = '{key: C1_KEY, ct: C1_CT, pt: C1_PT};
      vecs[1] = '{key: B_KEY,  ct: B_CT,  pt: B_PT};
      vecs[2] = '{key: C1_KEY, ct: C1_CT, pt: C1_PT};

      rst_n     = 1'b0;
      key_valid = 1'b0;
      key       = '0;
      in_valid  = 1'b1;
      in_data   = C1_CT;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_out_valid", 128'(out_valid), 128'd0);
      check("reset_out_data", out_data, 128'd0);
      check("reset_key_ready", 128'(key_ready), 128'd1);
      check("reset_in_ready", 128'(in_ready), 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Data offered before any key: held off until expansion completes.
      bad = 0;
      repeat (5) begin
         if (in_ready !== 1'b0) bad++;
         @(posedge clk);
         #1;
      end
      check("nokey_in_ready_low", 128'(bad), 128'd0);
      key_valid = 1'b1;
      key       = C1_KEY;
      @(posedge clk);
      #1;
      key_valid = 1'b0;
      n = 0;
      while (!in_ready && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("nokey_unblock_cycles", 128'(n), 128'd10);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_out(C1_PT, "nokey_block", 0, 0);

      for (int i = 0; i < 3; i++) begin
         load_key(vecs[i].key, $sformatf("vec%0d", i));
         run_block(vecs[i].ct, vecs[i].pt, $sformatf("vec%0d", i), 0);
      end

      run_block(C1_CT, C1_PT, "backpressure", 20);

      // Key and data offered together in idle: key wins.
      key_valid = 1'b1;
      key       = B_KEY;
      in_valid  = 1'b1;
      in_data   = C1_CT;
      #1;
      check("simul_in_ready", 128'(in_ready), 128'd0);
      check("simul_key_ready", 128'(key_ready), 128'd1);
      @(posedge clk);
      #1;
      key_valid = 1'b0;
      in_valid  = 1'b0;
      n = 0;
      while (!in_ready && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("simul_expand_cycles", 128'(n), 128'd10);
      check("simul_no_output", 128'(out_valid), 128'd0);
      run_block(B_CT, B_PT, "simul_newkey", 0);

      // Key offered mid-block must be ignored.
      check("keypulse_in_ready", 128'(in_ready), 128'd1);
      in_valid = 1'b1;
      in_data  = B_CT;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      key_valid = 1'b1;
      key       = C1_KEY;
      repeat (2) @(posedge clk);
      #1;
      check("keypulse_key_ready", 128'(key_ready), 128'd0);
      key_valid = 1'b0;
      wait_out(B_PT, "keypulse", 0, 2);
      run_block(B_CT, B_PT, "keypulse_after", 0);

      // Asynchronous reset in the middle of round 5.
      in_valid = 1'b1;
      in_data  = B_CT;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midreset_out_valid", 128'(out_valid), 128'd0);
      check("midreset_out_data", out_data, 128'd0);
      check("midreset_key_ready", 128'(key_ready), 128'd1);
      check("midreset_in_ready", 128'(in_ready), 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = C1_CT;
      bad = 0;
      repeat (3) begin
         if (in_ready !== 1'b0) bad++;
         @(posedge clk);
         #1;
      end
      check("postreset_in_ready_low", 128'(bad), 128'd0);
      in_valid = 1'b0;
      load_key(C1_KEY, "postreset");
      run_block(C1_CT, C1_PT, "postreset", 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
